parity_frame_arbiter: RTL
=========================

# parity_frame_arbiter

Round-robin scheduler that shares one serial parity-generating transmitter among NREQ parallel requesters. Accepts one W-bit word at a time through a valid/ready handshake, shifts it out LSB-first on a single serial line and appends a computed even-parity bit. It sits between word-level producers and the bit-serial parity datapath, sequencing framing, shifting and parity insertion.

## Interface
- NREQ, 2: number of requesters, legal 2..8
- W, 8: data word width, legal 2..32
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  bit i: requester i offers a word
- req_data  in  NREQ*W  word of requester i at bits [i*W +: W]
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i] at a rising edge
- ser_out  out  1  serial bit
- ser_valid  out  1  ser_out carries a frame bit this cycle
- ser_first  out  1  high on the first data bit of a frame
- ser_par  out  1  high on the parity-bit cycle
- grant_id  out  $clog2(NREQ)  index of the requester that owns the current frame
- busy  out  1  state != IDLE

## Operation
- States: IDLE, DATA, PAR, plus STOP when FRAME_STOP_EN is defined.
- IDLE: req_ready = one-hot of the round-robin winner among asserted req_valid; all zero if none valid. This is the only combinational input-to-output path. On transfer: shift register <= winning word, grant_id <= winner, rr pointer <= winner, bit counter <= 0, parity <= 0, next state DATA.
- Round-robin: search starts at (pointer+1) mod NREQ and wraps. Reset pointer = NREQ-1, so requester 0 wins first.
- DATA: ser_out = shreg[0], ser_valid = 1. Each cycle: shift right, parity ^= shreg[0], counter++. After W cycles (counter == W-1), next state PAR.
- PAR: ser_out = parity (XOR of the W data bits, giving even total ones), ser_valid = 1, ser_par = 1. Next state STOP if enabled, else IDLE.
- req_ready is all zero outside IDLE. req_valid and req_data changes after acceptance do not affect the frame in flight.
- ser_out, ser_valid, ser_first, ser_par and grant_id are Moore outputs, registered or decoded from registered state only.
- In IDLE: ser_valid = 0, ser_out = 0. grant_id holds its last value.

## Timing
- Reset values: state IDLE, ser_out 0, ser_valid 0, ser_first 0, ser_par 0, busy 0, grant_id 0, pointer NREQ-1, shreg 0, counter 0.
- Latency: first data bit appears the cycle after the accepting edge.
- Frame: W data cycles, then 1 parity cycle (+1 stop cycle if enabled), then at least 1 IDLE cycle. With continuous requests the period is W+2 cycles (W+3 with stop).
- Simultaneous valid on several requesters: exactly one is granted. No requester waits more than NREQ-1 frames.
- Reset mid-frame: all outputs return to their reset values immediately. The accepted word is discarded with no parity bit emitted and is not re-requested.
- A request arriving during a frame waits. Its req_valid must stay high until req_ready is seen.

## Configuration
- FRAME_STOP_EN defined: STOP state follows PAR for one cycle with ser_out = 1, ser_valid = 1, ser_par = 0. The frame is W+2 bits.
- FRAME_STOP_EN undefined: PAR goes directly to IDLE. The frame is W+1 bits.

## Test plan
- Single request, W=8, req_data 8'hA5 on requester 0 -> req_ready = 01 for one cycle; ser_out 1,0,1,0,0,1,0,1 with ser_first on the first bit; parity 0; ser_valid low afterwards.
- Requester 1 sends 8'h07 -> grant_id = 1; data bits 1,1,1,0,0,0,0,0; parity 1 with ser_par = 1.
- req_valid = 11 held continuously -> grants alternate 0,1,0,1; each req_ready pulse is W+2 = 10 cycles apart; every frame carries the correct requester's data.
- Reset asserted during data bit 3 -> ser_valid drops to 0 asynchronously. After release, requester 0 is granted first if both requesters are valid.
- Build with FRAME_STOP_EN, send 8'hFF -> 8 ones, parity 0, stop bit 1, then ser_valid = 0. The back-to-back period is 11 cycles.
- req_valid = 00 for 20 cycles -> busy = 0, req_ready = 00, ser_valid = 0 throughout.

Source files
------------

// File: rtl/parity_frame_arbiter.sv
// parity_frame_arbiter
// Shares one serial even-parity transmitter among NREQ requesters.
// The transmitter picks a requester round-robin, accepts that requester's
// word through a valid/ready handshake, sends the word LSB first, then
// sends its parity bit.
// Optional feature: define FRAME_STOP_EN to append a one-cycle stop bit
// (ser_out = 1) after the parity bit.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid[i]    requester i offers a word
//   req_data        requester i word at bits [i*W +: W]
//   req_ready       one-hot grant, combinational, only in IDLE
//   ser_out         serial bit
//   ser_valid       ser_out carries a frame bit
//   ser_first       first data bit of a frame
//   ser_par         parity-bit cycle
//   grant_id        index of the requester that owns the current frame
//   busy            a frame is in progress
module parity_frame_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      ser_out,
    output logic                      ser_valid,
    output logic                      ser_first,
    output logic                      ser_par,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            par_q, par_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic            ser_out_q, ser_out_d;
    logic            ser_valid_q, ser_valid_d;
    logic            ser_first_q, ser_first_d;
    logic            ser_par_q, ser_par_d;
    logic            busy_q, busy_d;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   idx;
    logic [W-1:0]    win_word;

    // Round-robin search: starts one past the last winner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        idx       = ptr_q;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = GW'((32'(ptr_q) + i) % NREQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign win_word = req_data[32'(win_idx)*W +: W];

    // Grant is offered only while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state and frame datapath.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    shreg_d = win_word;
                    gid_d   = win_idx;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                shreg_d = shreg_q >> 1;
                par_d   = par_q ^ shreg_q[0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_PAR;
                end
            end
            ST_PAR: begin
`ifdef FRAME_STOP_EN
                state_d = ST_STOP;
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from next-state values so they are registered.
    always_comb begin
        ser_valid_d = (state_d != ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        ser_first_d = (state_q == ST_IDLE) && (state_d == ST_DATA);
        ser_par_d   = (state_d == ST_PAR);
        case (state_d)
            ST_DATA: ser_out_d = shreg_d[0];
            ST_PAR:  ser_out_d = par_d;
            ST_STOP: ser_out_d = 1'b1;
            default: ser_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            gid_q       <= '0;
            ptr_q       <= GW'(NREQ - 1);
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_par_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            gid_q       <= gid_d;
            ptr_q       <= ptr_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_par_q   <= ser_par_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_par   = ser_par_q;
    assign grant_id  = gid_q;
    assign busy      = busy_q;

endmodule
